// File: rtl/mem_access_stage.sv
// mem_access_stage: RV32I memory-access stage.
// Holds the EX/MEM pipeline register and runs the data-memory request/ready/rvalid
// handshake. Loads are size-aligned and extended; stores get byte-lane enables.
// Ports:
//   clk, rst                        clock, synchronous active-high reset
//   ex_*                            instruction from EX (held while mem_stall=1)
//   mem_stall                       upstream hold, high whenever an access is in flight
//   dmem_req/we/addr/wdata/be       data-memory request (held until dmem_ready)
//   dmem_ready/rdata/rvalid         data-memory accept and read return
//   wb_valid/rd/reg_write/data      registered write-back result to MEM/WB
//   access_err                      pulse with wb_valid on a misaligned or illegal access
module mem_access_stage #(
    parameter int unsigned ADDR_WIDTH     = 32,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      ex_valid,
    input  logic [31:0]               ex_alu_result,
    input  logic [31:0]               ex_store_data,
    input  logic                      ex_mem_read,
    input  logic                      ex_mem_write,
    input  logic [2:0]                ex_funct3,
    input  logic [REG_ADDR_WIDTH-1:0] ex_rd,
    input  logic                      ex_reg_write,
    output logic                      mem_stall,
    output logic                      dmem_req,
    output logic                      dmem_we,
    output logic [ADDR_WIDTH-1:0]     dmem_addr,
    output logic [31:0]               dmem_wdata,
    output logic [3:0]                dmem_be,
    input  logic                      dmem_ready,
    input  logic [31:0]               dmem_rdata,
    input  logic                      dmem_rvalid,
    output logic                      wb_valid,
    output logic [REG_ADDR_WIDTH-1:0] wb_rd,
    output logic                      wb_reg_write,
    output logic [31:0]               wb_data,
    output logic                      access_err
);

    localparam int unsigned XLEN = 32;

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        ACCESS     = 2'd1,
        WAIT_RDATA = 2'd2
    } state_e;

    state_e                    state_q, state_d;
    logic                      req_q, req_d;
    logic                      we_q, we_d;
    logic [ADDR_WIDTH-1:0]     addr_q, addr_d;
    logic [3:0]                be_q, be_d;
    logic [XLEN-1:0]           wdata_q, wdata_d;
    logic [2:0]                f3_q, f3_d;
    logic [REG_ADDR_WIDTH-1:0] rd_q, rd_d;
    logic                      rw_q, rw_d;
    logic                      wb_valid_q, wb_valid_d;
    logic [REG_ADDR_WIDTH-1:0] wb_rd_q, wb_rd_d;
    logic                      wb_rw_q, wb_rw_d;
    logic [XLEN-1:0]           wb_data_q, wb_data_d;
    logic                      err_q, err_d;

    logic            is_mem;
    logic [1:0]      ex_off;
    logic            illegal;
    logic            misaligned;
    logic [3:0]      st_be;
    logic [XLEN-1:0] st_wdata;
    logic [XLEN-1:0] rdata_sh;
    logic [XLEN-1:0] ld_data;

    assign is_mem = ex_mem_read | ex_mem_write;
    assign ex_off = ex_alu_result[1:0];

    // Loads allow B/H/W and BU/HU; stores allow only B/H/W.
    assign illegal = ex_mem_read ? ((ex_funct3 == 3'b011) || (ex_funct3 == 3'b110) || (ex_funct3 == 3'b111))
                                 : (ex_funct3[2] || (ex_funct3[1:0] == 2'b11));
    assign misaligned = ((ex_funct3[1:0] == 2'b01) && ex_off[0]) ||
                        ((ex_funct3[1:0] == 2'b10) && (ex_off != 2'b00));

    // Store lanes: enables shifted to the byte offset, data replicated across lanes.
    always_comb begin
        st_be    = 4'b1111;
        st_wdata = ex_store_data;
        case (ex_funct3[1:0])
            2'b00: begin
                st_be    = 4'b0001 << ex_off;
                st_wdata = {4{ex_store_data[7:0]}};
            end
            2'b01: begin
                st_be    = 4'b0011 << ex_off;
                st_wdata = {2{ex_store_data[15:0]}};
            end
            default: begin
                st_be    = 4'b1111;
                st_wdata = ex_store_data;
            end
        endcase
    end

    // Load extract: bring the addressed byte/halfword down to bit 0, then extend.
    assign rdata_sh = dmem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        ld_data = dmem_rdata;
        case (f3_q)
            3'b000:  ld_data = {{24{rdata_sh[7]}}, rdata_sh[7:0]};
            3'b001:  ld_data = {{16{rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  ld_data = {24'd0, rdata_sh[7:0]};
            3'b101:  ld_data = {16'd0, rdata_sh[15:0]};
            default: ld_data = dmem_rdata;
        endcase
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d    = state_q;
        req_d      = req_q;
        we_d       = we_q;
        addr_d     = addr_q;
        be_d       = be_q;
        wdata_d    = wdata_q;
        f3_d       = f3_q;
        rd_d       = rd_q;
        rw_d       = rw_q;
        wb_valid_d = 1'b0;
        err_d      = 1'b0;
        wb_rd_d    = wb_rd_q;
        wb_rw_d    = wb_rw_q;
        wb_data_d  = wb_data_q;

        case (state_q)
            IDLE: begin
                if (ex_valid) begin
                    if (!is_mem) begin
                        wb_valid_d = 1'b1;
                        wb_data_d  = ex_alu_result;
                        wb_rd_d    = ex_rd;
                        wb_rw_d    = ex_reg_write;
                    end else if (illegal || misaligned) begin
                        wb_valid_d = 1'b1;
                        err_d      = 1'b1;
                        wb_rd_d    = ex_rd;
                        wb_rw_d    = 1'b0;
                    end else begin
                        state_d = ACCESS;
                        req_d   = 1'b1;
                        we_d    = ex_mem_write;
                        addr_d  = ADDR_WIDTH'(ex_alu_result);
                        f3_d    = ex_funct3;
                        rd_d    = ex_rd;
                        rw_d    = ex_reg_write;
                        be_d    = ex_mem_write ? st_be : 4'b1111;
                        wdata_d = ex_mem_write ? st_wdata : '0;
                    end
                end
            end
            ACCESS: begin
                if (dmem_ready) begin
                    req_d = 1'b0;
                    if (we_q) begin
                        state_d    = IDLE;
                        wb_valid_d = 1'b1;
                        wb_rd_d    = rd_q;
                        wb_rw_d    = 1'b0;
                    end else begin
                        state_d = WAIT_RDATA;
                    end
                end
            end
            WAIT_RDATA: begin
                if (dmem_rvalid) begin
                    state_d    = IDLE;
                    wb_valid_d = 1'b1;
                    wb_data_d  = ld_data;
                    wb_rd_d    = rd_q;
                    wb_rw_d    = rw_q;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and output registers; reset drops any outstanding request.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            req_q      <= 1'b0;
            we_q       <= 1'b0;
            addr_q     <= '0;
            be_q       <= '0;
            wdata_q    <= '0;
            f3_q       <= '0;
            rd_q       <= '0;
            rw_q       <= 1'b0;
            wb_valid_q <= 1'b0;
            wb_rd_q    <= '0;
            wb_rw_q    <= 1'b0;
            wb_data_q  <= '0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            req_q      <= req_d;
            we_q       <= we_d;
            addr_q     <= addr_d;
            be_q       <= be_d;
            wdata_q    <= wdata_d;
            f3_q       <= f3_d;
            rd_q       <= rd_d;
            rw_q       <= rw_d;
            wb_valid_q <= wb_valid_d;
            wb_rd_q    <= wb_rd_d;
            wb_rw_q    <= wb_rw_d;
            wb_data_q  <= wb_data_d;
            err_q      <= err_d;
        end
    end

    assign mem_stall    = (state_q != IDLE);
    assign dmem_req     = req_q;
    assign dmem_we      = we_q;
    assign dmem_addr    = {addr_q[ADDR_WIDTH-1:2], 2'b00};
    assign dmem_wdata   = wdata_q;
    assign dmem_be      = be_q;
    assign wb_valid     = wb_valid_q;
    assign wb_rd        = wb_rd_q;
    assign wb_reg_write = wb_rw_q;
    assign wb_data      = wb_data_q;
    assign access_err   = err_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Self-checking bench for mem_access_stage: directed scenarios plus randomized
// operations compared against an arithmetic reference model.
module tb_mem_access_stage;

    logic        clk;
    logic        rst;
    logic        ex_valid;
    logic [31:0] ex_alu_result;
    logic [31:0] ex_store_data;
    logic        ex_mem_read;
    logic        ex_mem_write;
    logic [2:0]  ex_funct3;
    logic [4:0]  ex_rd;
    logic        ex_reg_write;
    logic        mem_stall;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic [31:0] dmem_rdata;
    logic        dmem_rvalid;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic        wb_reg_write;
    logic [31:0] wb_data;
    logic        access_err;

    int checks;
    int failures;

    mem_access_stage #(.ADDR_WIDTH(32), .REG_ADDR_WIDTH(5)) dut (
        .clk(clk), .rst(rst),
        .ex_valid(ex_valid), .ex_alu_result(ex_alu_result), .ex_store_data(ex_store_data),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write), .ex_funct3(ex_funct3),
        .ex_rd(ex_rd), .ex_reg_write(ex_reg_write),
        .mem_stall(mem_stall),
        .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_be(dmem_be),
        .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata), .dmem_rvalid(dmem_rvalid),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_reg_write(wb_reg_write),
        .wb_data(wb_data), .access_err(access_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] alu;
        logic [31:0] sdata;
        logic [4:0]  rd;
        logic        rw;
        logic        ld;
        logic        st;
        logic [2:0]  f3;
        logic [3:0]  rdly;
        logic [3:0]  vdly;
        logic [31:0] rdata;
    } op_t;

    typedef struct packed {
        logic [7:0]  wb_cnt;
        logic [7:0]  latency;
        logic [7:0]  req_cycles;
        logic [31:0] wb_data;
        logic [4:0]  wb_rd;
        logic        wb_rw;
        logic        err;
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic        unstable;
        logic        stall_bad;
        logic        hold_bad;
        logic        timeout;
    } obs_t;

    localparam int unsigned OUTS_W = 111;

    function automatic logic [OUTS_W-1:0] outs_flat();
        return {mem_stall, dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
                wb_valid, wb_rd, wb_reg_write, wb_data, access_err};
    endfunction

    function automatic op_t mk(input logic [31:0] alu, input logic [31:0] sdata,
                               input logic [4:0] rd, input logic rw, input logic ld,
                               input logic st, input logic [2:0] f3, input logic [3:0] rdly,
                               input logic [3:0] vdly, input logic [31:0] rdata);
        op_t op;
        op.alu = alu; op.sdata = sdata; op.rd = rd; op.rw = rw; op.ld = ld; op.st = st;
        op.f3 = f3; op.rdly = rdly; op.vdly = vdly; op.rdata = rdata;
        return op;
    endfunction

    // Reference model: access size in bytes, legality, lanes and load value.
    function automatic int unsigned m_size(input logic [2:0] f3);
        return 32'd1 << f3[1:0];
    endfunction

    function automatic logic m_err(input op_t op);
        int unsigned n;
        int unsigned off;
        logic legal;
        n   = m_size(op.f3);
        off = 32'(op.alu[1:0]);
        if (op.ld) legal = (op.f3 == 3'd0) || (op.f3 == 3'd1) || (op.f3 == 3'd2) ||
                           (op.f3 == 3'd4) || (op.f3 == 3'd5);
        else       legal = (op.f3 <= 3'd2);
        return !legal || ((off % n) != 0);
    endfunction

    function automatic logic [3:0] m_be(input op_t op);
        int unsigned n;
        int unsigned mask;
        if (op.ld) return 4'hF;
        n    = m_size(op.f3);
        mask = ((32'd1 << n) - 1) << op.alu[1:0];
        return 4'(mask);
    endfunction

    function automatic logic [31:0] m_wdata(input op_t op);
        logic [31:0] w;
        int unsigned n;
        n = m_size(op.f3);
        w = '0;
        for (int i = 0; i < 4; i++) w[8*i +: 8] = op.sdata[8*(i % n) +: 8];
        return w;
    endfunction

    function automatic logic [31:0] m_load(input op_t op);
        longint unsigned v;
        int unsigned n;
        n = m_size(op.f3);
        if (n >= 4) return op.rdata;
        v = 64'(op.rdata) >> (8 * op.alu[1:0]);
        v = v & ((64'd1 << (8 * n)) - 1);
        if (!op.f3[2] && (v >= (64'd1 << (8 * n - 1)))) v = v - (64'd1 << (8 * n));
        return 32'(v);
    endfunction

    // Issues one instruction, plays memory (ready after rdly request cycles,
    // rvalid vdly cycles into the read wait) and records what the DUT did.
    task automatic run_op(input op_t op, output obs_t o);
        int k;
        int w;
        bit rdy_last;
        bit waiting;
        bit done;
        logic [31:0] held;
        o = '0; k = 0; w = 0; rdy_last = 0; waiting = 0; done = 0;
        @(negedge clk);
        ex_valid = 1'b1; ex_alu_result = op.alu; ex_store_data = op.sdata;
        ex_mem_read = op.ld; ex_mem_write = op.st; ex_funct3 = op.f3;
        ex_rd = op.rd; ex_reg_write = op.rw;
        for (int cyc = 0; cyc < 64 && !done; cyc++) begin
            @(negedge clk);
            dmem_ready = 1'b0;
            dmem_rvalid = 1'b0;
            if (mem_stall === wb_valid) o.stall_bad = 1'b1;
            if (wb_valid === 1'b1) begin
                o.wb_cnt = o.wb_cnt + 8'd1;
                o.wb_data = wb_data; o.wb_rd = wb_rd; o.wb_rw = wb_reg_write;
                o.err = access_err; o.latency = 8'(cyc + 1);
                done = 1;
            end
            if (dmem_req === 1'b1) begin
                if (o.req_cycles == 8'd0) begin
                    o.addr = dmem_addr; o.be = dmem_be; o.wdata = dmem_wdata; o.we = dmem_we;
                end else if ({dmem_addr, dmem_be, dmem_wdata, dmem_we} !== {o.addr, o.be, o.wdata, o.we}) begin
                    o.unstable = 1'b1;
                end
                o.req_cycles = o.req_cycles + 8'd1;
                if (k == int'(op.rdly)) dmem_ready = 1'b1;
                k++;
            end
            if (rdy_last && op.ld) waiting = 1;
            rdy_last = dmem_ready;
            if (waiting && !done) begin
                if (w == int'(op.vdly)) begin
                    dmem_rvalid = 1'b1;
                    dmem_rdata = op.rdata;
                end
                w++;
            end
        end
        ex_valid = 1'b0;
        if (!done) o.timeout = 1'b1;
        held = wb_data;
        // Idle tail: a stray rvalid must be ignored and wb fields must hold.
        for (int j = 0; j < 3; j++) begin
            dmem_rvalid = (j == 0);
            dmem_rdata = $urandom();
            @(negedge clk);
            if (wb_valid === 1'b1) o.wb_cnt = o.wb_cnt + 8'd1;
            if (wb_data !== held) o.hold_bad = 1'b1;
        end
        dmem_rvalid = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks++;
        if (outs_flat() !== '0) begin
            failures++;
            $display("FAIL reset_outputs got=%h exp=0", outs_flat());
        end
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (outs_flat() !== '0) begin
            failures++;
            $display("FAIL reset_idle_outputs got=%h exp=0", outs_flat());
        end
    endtask

    task automatic test_alu_passthrough();
        @(negedge clk);
        ex_valid = 1'b1; ex_alu_result = 32'h0000_1234; ex_rd = 5'd5; ex_reg_write = 1'b1;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = 3'd0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (i == 2) ex_valid = 1'b0;
            checks++;
            if ({wb_valid, wb_data, wb_rd, wb_reg_write, mem_stall, access_err} !==
                {1'b1, 32'h0000_1234, 5'd5, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL passthru_%0d got v=%b d=%h rd=%0d rw=%b stall=%b err=%b exp v=1 d=00001234 rd=5 rw=1 stall=0 err=0",
                         i, wb_valid, wb_data, wb_rd, wb_reg_write, mem_stall, access_err);
            end
        end
        @(negedge clk);
        checks++;
        if ({wb_valid, wb_data} !== {1'b0, 32'h0000_1234}) begin
            failures++;
            $display("FAIL passthru_hold got v=%b d=%h exp v=0 d=00001234", wb_valid, wb_data);
        end
    endtask

    task automatic test_store_sb();
        obs_t o;
        run_op(mk(32'h0000_1003, 32'hAABB_CCDD, 5'd9, 1'b1, 1'b0, 1'b1, 3'b000, 4'd2, 4'd0, 32'd0), o);
        checks++;
        if ({o.req_cycles, o.addr, o.be, o.wdata, o.we} !== {8'd3, 32'h0000_1000, 4'b1000, 32'hDDDD_DDDD, 1'b1}) begin
            failures++;
            $display("FAIL sb_request got req=%0d addr=%h be=%b wdata=%h we=%b exp req=3 addr=00001000 be=1000 wdata=dddddddd we=1",
                     o.req_cycles, o.addr, o.be, o.wdata, o.we);
        end
        checks++;
        if ({o.wb_cnt, o.wb_rw, o.err, o.stall_bad, o.unstable, o.latency} !== {8'd1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd4}) begin
            failures++;
            $display("FAIL sb_retire got cnt=%0d rw=%b err=%b stall_bad=%b unstable=%b lat=%0d exp cnt=1 rw=0 err=0 stall_bad=0 unstable=0 lat=4",
                     o.wb_cnt, o.wb_rw, o.err, o.stall_bad, o.unstable, o.latency);
        end
    endtask

    task automatic test_loads();
        obs_t o;
        logic [31:0] exp_d [3];
        op_t ops [3];
        ops[0] = mk(32'h0000_2002, 32'd0, 5'd3, 1'b1, 1'b1, 1'b0, 3'b000, 4'd0, 4'd1, 32'h0080_0000);
        ops[1] = mk(32'h0000_2002, 32'd0, 5'd4, 1'b1, 1'b1, 1'b0, 3'b100, 4'd1, 4'd0, 32'h0080_0000);
        ops[2] = mk(32'h0000_2002, 32'd0, 5'd6, 1'b1, 1'b1, 1'b0, 3'b001, 4'd0, 4'd0, 32'h8001_0000);
        exp_d[0] = 32'hFFFF_FF80;
        exp_d[1] = 32'h0000_0080;
        exp_d[2] = 32'hFFFF_8001;
        for (int i = 0; i < 3; i++) begin
            run_op(ops[i], o);
            checks++;
            if ({o.wb_cnt, o.wb_data, o.wb_rd, o.wb_rw, o.err} !== {8'd1, exp_d[i], ops[i].rd, 1'b1, 1'b0}) begin
                failures++;
                $display("FAIL load_%0d got cnt=%0d d=%h rd=%0d rw=%b err=%b exp cnt=1 d=%h rd=%0d rw=1 err=0",
                         i, o.wb_cnt, o.wb_data, o.wb_rd, o.wb_rw, o.err, exp_d[i], ops[i].rd);
            end
            checks++;
            if ({o.addr, o.be, o.we} !== {32'h0000_2000, 4'hF, 1'b0}) begin
                failures++;
                $display("FAIL load_req_%0d got addr=%h be=%b we=%b exp addr=00002000 be=1111 we=0",
                         i, o.addr, o.be, o.we);
            end
        end
    endtask

    task automatic test_access_err();
        obs_t o;
        op_t ops [2];
        ops[0] = mk(32'h0000_3001, 32'd0, 5'd7, 1'b1, 1'b1, 1'b0, 3'b010, 4'd0, 4'd0, 32'd0);
        ops[1] = mk(32'h0000_3000, 32'h1234_5678, 5'd8, 1'b1, 1'b0, 1'b1, 3'b011, 4'd0, 4'd0, 32'd0);
        for (int i = 0; i < 2; i++) begin
            run_op(ops[i], o);
            checks++;
            if ({o.wb_cnt, o.err, o.wb_rw, o.req_cycles, o.latency, o.stall_bad} !==
                {8'd1, 1'b1, 1'b0, 8'd0, 8'd1, 1'b0}) begin
                failures++;
                $display("FAIL access_err_%0d got cnt=%0d err=%b rw=%b req=%0d lat=%0d stall_bad=%b exp cnt=1 err=1 rw=0 req=0 lat=1 stall_bad=0",
                         i, o.wb_cnt, o.err, o.wb_rw, o.req_cycles, o.latency, o.stall_bad);
            end
        end
    endtask

    task automatic test_reset_in_wait();
        int wb_seen;
        wb_seen = 0;
        @(negedge clk);
        ex_valid = 1'b1; ex_alu_result = 32'h0000_4000; ex_mem_read = 1'b1; ex_mem_write = 1'b0;
        ex_funct3 = 3'b010; ex_rd = 5'd11; ex_reg_write = 1'b1;
        @(negedge clk);
        checks++;
        if ({dmem_req, mem_stall} !== 2'b11) begin
            failures++;
            $display("FAIL rstwait_access got req=%b stall=%b exp req=1 stall=1", dmem_req, mem_stall);
        end
        dmem_ready = 1'b1;
        @(negedge clk);
        dmem_ready = 1'b0;
        checks++;
        if ({dmem_req, mem_stall, wb_valid} !== 3'b010) begin
            failures++;
            $display("FAIL rstwait_wait got req=%b stall=%b wbv=%b exp req=0 stall=1 wbv=0", dmem_req, mem_stall, wb_valid);
        end
        rst = 1'b1;
        ex_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        checks++;
        if (outs_flat() !== '0) begin
            failures++;
            $display("FAIL rstwait_outputs got=%h exp=0", outs_flat());
        end
        dmem_rvalid = 1'b1;
        dmem_rdata = 32'hCAFE_F00D;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            dmem_rvalid = 1'b0;
            if (wb_valid !== 1'b0 || mem_stall !== 1'b0) wb_seen++;
        end
        checks++;
        if (wb_seen != 0 || outs_flat() !== '0) begin
            failures++;
            $display("FAIL rstwait_late_rvalid got bad_cycles=%0d outs=%h exp bad_cycles=0 outs=0", wb_seen, outs_flat());
        end
    endtask

    task automatic test_lw_long_latency();
        obs_t o;
        run_op(mk(32'h0000_5000, 32'd0, 5'd12, 1'b1, 1'b1, 1'b0, 3'b010, 4'd0, 4'd3, 32'hDEAD_BEEF), o);
        checks++;
        if ({o.wb_cnt, o.wb_data, o.wb_rw, o.stall_bad, o.latency, o.req_cycles} !==
            {8'd1, 32'hDEAD_BEEF, 1'b1, 1'b0, 8'd6, 8'd1}) begin
            failures++;
            $display("FAIL lw_long got cnt=%0d d=%h rw=%b stall_bad=%b lat=%0d req=%0d exp cnt=1 d=deadbeef rw=1 stall_bad=0 lat=6 req=1",
                     o.wb_cnt, o.wb_data, o.wb_rw, o.stall_bad, o.latency, o.req_cycles);
        end
    endtask

    task automatic test_random();
        obs_t o;
        op_t op;
        logic e_err;
        logic e_mem;
        logic e_rw;
        logic [31:0] e_data;
        int e_lat;
        int kind;
        for (int i = 0; i < 60; i++) begin
            kind = int'($urandom_range(0, 2));
            op = mk($urandom(), $urandom(), 5'($urandom()), 1'($urandom()),
                    kind == 1, kind == 2, 3'($urandom()), 4'($urandom_range(0, 3)),
                    4'($urandom_range(0, 3)), $urandom());
            if ($urandom_range(0, 3) != 0) op.alu[1:0] = 2'b00;
            e_mem = op.ld | op.st;
            e_err = e_mem && m_err(op);
            e_rw  = !e_mem ? op.rw : (op.ld && !e_err) ? op.rw : 1'b0;
            e_data = !e_mem ? op.alu : m_load(op);
            e_lat = (!e_mem || e_err) ? 1 : op.st ? int'(op.rdly) + 2 : int'(op.rdly) + int'(op.vdly) + 3;
            run_op(op, o);
            checks++;
            if ({o.wb_cnt, o.err, o.wb_rw, o.timeout} !== {8'd1, e_err, e_rw, 1'b0}) begin
                failures++;
                $display("FAIL rnd_retire op=%0d got cnt=%0d err=%b rw=%b to=%b exp cnt=1 err=%b rw=%b to=0",
                         i, o.wb_cnt, o.err, o.wb_rw, o.timeout, e_err, e_rw);
            end
            checks++;
            if (o.latency !== 8'(e_lat)) begin
                failures++;
                $display("FAIL rnd_latency op=%0d got=%0d exp=%0d", i, o.latency, e_lat);
            end
            checks++;
            if ({o.stall_bad, o.unstable, o.hold_bad} !== 3'b000) begin
                failures++;
                $display("FAIL rnd_protocol op=%0d got stall_bad=%b unstable=%b hold_bad=%b exp 000",
                         i, o.stall_bad, o.unstable, o.hold_bad);
            end
            if (!e_err) begin
                checks++;
                if (o.wb_rd !== op.rd) begin
                    failures++;
                    $display("FAIL rnd_rd op=%0d got=%0d exp=%0d", i, o.wb_rd, op.rd);
                end
            end
            if (!op.st && !e_err) begin
                checks++;
                if (o.wb_data !== e_data) begin
                    failures++;
                    $display("FAIL rnd_data op=%0d f3=%0d addr=%h rdata=%h got=%h exp=%h",
                             i, op.f3, op.alu, op.rdata, o.wb_data, e_data);
                end
            end
            if (e_mem && !e_err) begin
                checks++;
                if ({o.req_cycles, o.addr, o.be, o.we} !==
                    {8'(int'(op.rdly) + 1), {op.alu[31:2], 2'b00}, m_be(op), op.st}) begin
                    failures++;
                    $display("FAIL rnd_req op=%0d got req=%0d addr=%h be=%b we=%b exp req=%0d addr=%h be=%b we=%b",
                             i, o.req_cycles, o.addr, o.be, o.we, int'(op.rdly) + 1,
                             {op.alu[31:2], 2'b00}, m_be(op), op.st);
                end
            end else begin
                checks++;
                if (o.req_cycles !== 8'd0) begin
                    failures++;
                    $display("FAIL rnd_noreq op=%0d got req=%0d exp=0", i, o.req_cycles);
                end
            end
            if (op.st && !e_err) begin
                checks++;
                if (o.wdata !== m_wdata(op)) begin
                    failures++;
                    $display("FAIL rnd_wdata op=%0d f3=%0d got=%h exp=%h", i, op.f3, o.wdata, m_wdata(op));
                end
            end
        end
    endtask

    initial begin
        checks = 0;
        failures = 0;
        rst = 1'b1;
        ex_valid = 1'b0; ex_alu_result = '0; ex_store_data = '0;
        ex_mem_read = 1'b0; ex_mem_write = 1'b0; ex_funct3 = '0;
        ex_rd = '0; ex_reg_write = 1'b0;
        dmem_ready = 1'b0; dmem_rdata = '0; dmem_rvalid = 1'b0;
        test_reset();
        test_alu_passthrough();
        test_store_sb();
        test_loads();
        test_access_err();
        test_reset_in_wait();
        test_lw_long_latency();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog time limit reached checks=%0d", checks);
        $fatal(1, "watchdog");
    end

endmodule
